// File: rtl/mp_link_ctrl.sv
// Two-board multiplayer session controller: READY handshake, heartbeats,
// loss reporting and link timeout on top of a byte-level UART.
module mp_link_ctrl #(
    parameter int unsigned HEARTBEAT_CYCLES = 6_500_000,
    parameter int unsigned TIMEOUT_CYCLES   = 32_500_000,
    parameter logic [7:0]  CODE_READY       = 8'hA5,
    parameter logic [7:0]  CODE_HEARTBEAT   = 8'h5A,
    parameter logic [7:0]  CODE_LOST        = 8'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       multiplayer,
    input  logic       player_ready,
    input  logic       game_over,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       opponent_ready,
    output logic       victory,
    output logic       link_lost,
    output logic [2:0] state
);

    localparam int HB_W = $clog2(HEARTBEAT_CYCLES) + 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ANNOUNCE  = 3'd1,
        S_PLAYING   = 3'd2,
        S_LOST      = 3'd3,
        S_WON       = 3'd4,
        S_LINK_DOWN = 3'd5
    } state_t;

    // Encoding order doubles as transmit priority.
    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_HB    = 2'd1,
        REQ_READY = 2'd2,
        REQ_LOST  = 2'd3
    } req_t;

    state_t          r_state;
    req_t            r_pend;
    logic            r_opp_seen;
    logic            r_victory;
    logic            r_link_lost;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic [HB_W-1:0] r_hb_cnt;
    logic [TO_W-1:0] r_to_cnt;

    logic            w_rx_ready;
    logic            w_rx_lost;
    logic            w_rx_known;
    logic            w_hb_wrap;
    logic            w_issue;
    req_t            w_req;
    req_t            w_pend_nxt;
    logic [7:0]      w_pend_code;

    assign w_rx_ready = rx_valid && (rx_data == CODE_READY);
    assign w_rx_lost  = rx_valid && (rx_data == CODE_LOST);
    assign w_rx_known = w_rx_ready || w_rx_lost ||
                        (rx_valid && (rx_data == CODE_HEARTBEAT));
    assign w_hb_wrap  = (r_hb_cnt == HB_LAST);
    // The guard on r_tx_start keeps pulses at least one idle cycle apart.
    assign w_issue    = (r_pend != REQ_NONE) && !tx_busy && !r_tx_start;

    always_comb begin
        w_req = REQ_NONE;
        case (r_state)
            S_IDLE:     if (player_ready) w_req = REQ_READY;
            S_ANNOUNCE: if (w_hb_wrap) w_req = REQ_READY;
            S_PLAYING: begin
                if (game_over)      w_req = REQ_LOST;
                else if (w_hb_wrap) w_req = REQ_HB;
            end
            default:    w_req = REQ_NONE;
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_issue)
            w_pend_nxt = w_req;
        else if (w_req > r_pend)
            w_pend_nxt = w_req;
    end

    always_comb begin
        case (r_pend)
            REQ_LOST:  w_pend_code = CODE_LOST;
            REQ_READY: w_pend_code = CODE_READY;
            REQ_HB:    w_pend_code = CODE_HEARTBEAT;
            default:   w_pend_code = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pend      <= REQ_NONE;
            r_opp_seen  <= 1'b0;
            r_victory   <= 1'b0;
            r_link_lost <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_hb_cnt    <= '0;
            r_to_cnt    <= '0;
        end else if (!multiplayer) begin
            r_state     <= S_IDLE;
            r_pend      <= REQ_NONE;
            r_opp_seen  <= 1'b0;
            r_victory   <= 1'b0;
            r_link_lost <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_hb_cnt    <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_tx_start <= w_issue;
            if (w_issue)
                r_tx_data <= w_pend_code;
            r_pend <= w_pend_nxt;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_ready)
                        r_opp_seen <= 1'b1;
                    if (player_ready) begin
                        r_hb_cnt <= '0;
                        r_to_cnt <= '0;
                        r_state  <= (r_opp_seen || w_rx_ready) ? S_PLAYING : S_ANNOUNCE;
                    end
                end
                S_ANNOUNCE: begin
                    r_hb_cnt <= w_hb_wrap ? '0 : r_hb_cnt + 1'b1;
                    if (w_rx_ready) begin
                        r_opp_seen <= 1'b1;
                        r_hb_cnt   <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= S_PLAYING;
                    end
                end
                S_PLAYING: begin
                    r_hb_cnt <= w_hb_wrap ? '0 : r_hb_cnt + 1'b1;
                    if (w_rx_known)
                        r_to_cnt <= '0;
                    else if (r_to_cnt != TO_MAX)
                        r_to_cnt <= r_to_cnt + 1'b1;
                    // Local loss outranks a simultaneous remote loss.
                    if (game_over) begin
                        r_state <= S_LOST;
                    end else if (w_rx_lost) begin
                        r_state   <= S_WON;
                        r_victory <= 1'b1;
                    end else if (!w_rx_known && r_to_cnt == TO_LAST) begin
                        r_state     <= S_LINK_DOWN;
                        r_link_lost <= 1'b1;
                    end
                end
                S_LOST, S_WON, S_LINK_DOWN: begin
                    r_state <= r_state;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state          = r_state;
    assign tx_data        = r_tx_data;
    assign tx_start       = r_tx_start;
    assign opponent_ready = r_opp_seen;
    assign victory        = r_victory;
    assign link_lost      = r_link_lost;

endmodule
